// File: rtl/pipe_defs.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_defs
//  Brief    : Shared encodings for the decode-stage hazard/control logic.
//  Revision : 1.0
// ============================================================================
package pipe_defs;

   localparam logic [1:0] IF_SEL_NPC = 2'b00;
   localparam logic [1:0] IF_SEL_ALU = 2'b01;
   localparam logic [1:0] IF_SEL_TA  = 2'b10;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 7
   localparam int WAIT_W = 3;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } st_t;

endpackage
`default_nettype wire

// File: rtl/hz_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module   : hz_fwd_sel
//  Brief    : Per-operand forwarding source select, priority EX > MEM > WB.
//  Revision : 1.0
// ============================================================================
module hz_fwd_sel
   import pipe_defs::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] ex_rd,
   input  logic       ex_we,
   input  logic [4:0] mem_rd,
   input  logic       mem_we,
   input  logic [4:0] wb_rd,
   input  logic       wb_we,
   output logic [1:0] sel
);

   // %g0 reads as zero, so it is never bypassed
   always_comb begin
      sel = FWD_REG;
      if (rs != 5'd0) begin
         if (ex_we && (ex_rd == rs))
            sel = FWD_EX;
         else if (mem_we && (mem_rd == rs))
            sel = FWD_MEM;
         else if (wb_we && (wb_rd == rs))
            sel = FWD_WB;
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_ctrl
//  Brief    : Decode-stage load-use stall, branch/JMPL steering, delay-slot
//             annul, operand forwarding select and event counters.
//  Revision : 1.0
// ============================================================================
module id_hazard_ctrl
   import pipe_defs::*;
#(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             R,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_branch,
   input  logic             id_taken,
   input  logic             id_uncond,
   input  logic             id_annul,
   input  logic             id_jmpl,
   input  logic [4:0]       ex_rd,
   input  logic             ex_we,
   input  logic             ex_load,
   input  logic [4:0]       mem_rd,
   input  logic             mem_we,
   input  logic [4:0]       wb_rd,
   input  logic             wb_we,
   output logic             pc_le,
   output logic             ifid_le,
   output logic             ch_clear,
   output logic             idex_bubble,
   output logic [1:0]       if_sel,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] annul_cnt
);

   localparam logic [WAIT_W-1:0] c_WAIT_INIT = WAIT_W'(LOAD_LAT - 1);
   localparam logic [WAIT_W-1:0] c_WAIT_ONE  = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

   st_t               r_state;
   st_t               w_state_nxt;
   logic [WAIT_W-1:0] r_wait;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_annul_cnt;
   logic              w_hz;
   logic              w_stall;

   assign w_hz = ex_load && ex_we && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         r_state <= RUN;
         r_wait  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_stall     = 1'b0;
      pc_le       = 1'b1;
      ifid_le     = 1'b1;
      ch_clear    = 1'b0;
      idex_bubble = 1'b0;
      if_sel      = IF_SEL_NPC;

      // The hazard cycle itself is the first stall cycle; STALL covers the rest
      case (r_state)
         RUN: begin
            w_stall = w_hz;
            if (w_hz && (LOAD_LAT > 1)) begin
               w_state_nxt = STALL;
               w_wait_nxt  = c_WAIT_INIT;
            end
         end
         STALL: begin
            w_stall    = 1'b1;
            w_wait_nxt = r_wait - c_WAIT_ONE;
            if (r_wait == c_WAIT_ONE)
               w_state_nxt = RUN;
         end
         default: w_state_nxt = RUN;
      endcase

      if (w_stall) begin
         pc_le       = 1'b0;
         ifid_le     = 1'b0;
         idex_bubble = 1'b1;
      end else begin
         if (id_jmpl)
            if_sel = IF_SEL_ALU;
         else if (id_branch && id_taken)
            if_sel = IF_SEL_TA;
         // BA,a and untaken conditional with a=1 both kill the delay slot
         ch_clear = id_branch && id_annul && (!id_taken || id_uncond);
      end
   end

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         r_stall_cnt <= '0;
         r_annul_cnt <= '0;
      end else begin
         if (w_stall)
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
         if (ch_clear)
            r_annul_cnt <= r_annul_cnt + c_CNT_ONE;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign annul_cnt = r_annul_cnt;

   hz_fwd_sel u_fwd_a (
      .rs     (id_rs1),
      .ex_rd  (ex_rd),
      .ex_we  (ex_we),
      .mem_rd (mem_rd),
      .mem_we (mem_we),
      .wb_rd  (wb_rd),
      .wb_we  (wb_we),
      .sel    (fwd_a)
   );

   hz_fwd_sel u_fwd_b (
      .rs     (id_rs2),
      .ex_rd  (ex_rd),
      .ex_we  (ex_we),
      .mem_rd (mem_rd),
      .mem_we (mem_we),
      .wb_rd  (wb_rd),
      .wb_we  (wb_we),
      .sel    (fwd_b)
   );

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_hazard_ctrl
//  Brief    : Scoreboard bench for id_hazard_ctrl, LOAD_LAT=1 and LOAD_LAT=3.
//  Revision : 1.0
// ============================================================================
module tb_id_hazard_ctrl;

   logic       clk = 1'b0;
   logic       R;
   logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, id_branch, id_taken, id_uncond;
   logic       id_annul, id_jmpl, ex_we, ex_load, mem_we, wb_we;

   logic        pc_le1, ifid_le1, ch_clear1, idex_bubble1;
   logic [1:0]  if_sel1, fwd_a1, fwd_b1;
   logic [15:0] stall_cnt1, annul_cnt1;
   logic        pc_le3, ifid_le3, ch_clear3, idex_bubble3;
   logic [1:0]  if_sel3, fwd_a3, fwd_b3;
   logic [3:0]  stall_cnt3, annul_cnt3;

   always #5 clk = ~clk;

   id_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
      .clk(clk), .R(R), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_branch(id_branch),
      .id_taken(id_taken), .id_uncond(id_uncond), .id_annul(id_annul),
      .id_jmpl(id_jmpl), .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
      .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
      .pc_le(pc_le1), .ifid_le(ifid_le1), .ch_clear(ch_clear1),
      .idex_bubble(idex_bubble1), .if_sel(if_sel1), .fwd_a(fwd_a1),
      .fwd_b(fwd_b1), .stall_cnt(stall_cnt1), .annul_cnt(annul_cnt1)
   );

   id_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) dut3 (
      .clk(clk), .R(R), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_branch(id_branch),
      .id_taken(id_taken), .id_uncond(id_uncond), .id_annul(id_annul),
      .id_jmpl(id_jmpl), .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
      .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
      .pc_le(pc_le3), .ifid_le(ifid_le3), .ch_clear(ch_clear3),
      .idex_bubble(idex_bubble3), .if_sel(if_sel3), .fwd_a(fwd_a3),
      .fwd_b(fwd_b3), .stall_cnt(stall_cnt3), .annul_cnt(annul_cnt3)
   );

   // ctl = {pc_le, ifid_le, ch_clear, idex_bubble, if_sel}
   localparam logic [5:0] RUNC = 6'b110000;
   localparam logic [5:0] STL  = 6'b000100;

   typedef struct packed {
      logic [5:0] c1;
      logic [5:0] c3;
      logic [3:0] fwd;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   logic [15:0] m_st1, m_an1;
   logic [3:0]  m_st3, m_an3;

   wire [19:0] obs = {pc_le1, ifid_le1, ch_clear1, idex_bubble1, if_sel1,
                      pc_le3, ifid_le3, ch_clear3, idex_bubble3, if_sel3,
                      fwd_a1, fwd_b1, fwd_a3, fwd_b3};
   wire [39:0] cnt_obs = {stall_cnt1, annul_cnt1, stall_cnt3, annul_cnt3};

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_branch = 1'b0; id_taken = 1'b0;
      id_uncond = 1'b0; id_annul = 1'b0; id_jmpl = 1'b0; ex_we = 1'b0;
      ex_load = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
   endtask

   // Clock edge plus reference counter update from the expected controls
   task automatic advance(input exp_t e);
      @(posedge clk);
      #1;
      if (R) begin
         m_st1 = m_st1 + 16'(e.c1[2]);
         m_an1 = m_an1 + 16'(e.c1[3]);
         m_st3 = m_st3 + 4'(e.c3[2]);
         m_an3 = m_an3 + 4'(e.c3[3]);
      end else begin
         m_st1 = '0; m_an1 = '0; m_st3 = '0; m_an3 = '0;
      end
   endtask

   task automatic test_reset();
      exp_t e;
      R = 1'b0;
      clear_inputs();
      m_st1 = '0; m_an1 = '0; m_st3 = '0; m_an3 = '0;
      sb.push_back({RUNC, RUNC, 4'b0000});
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      if (obs !== {e, e.fwd}) $display("FAIL reset_ctl got %b want %b", obs, {e, e.fwd});
      else n_pass++;
      n_total++;
      if (cnt_obs !== 40'd0) $display("FAIL reset_cnt got %h want %h", cnt_obs, 40'd0);
      else n_pass++;
      advance(e);
      R = 1'b1;
   endtask

   task automatic test_load_use();
      exp_t e;
      for (int v = 0; v < 2; v++) begin
         for (int c = 0; c < 4; c++) begin
            clear_inputs();
            if (c == 0) begin
               ex_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd5;
               if (v == 0) begin id_rs1 = 5'd5; id_use_rs1 = 1'b1; end
               else        begin id_rs2 = 5'd5; id_use_rs2 = 1'b1; end
            end
            sb.push_back({(c == 0) ? STL : RUNC, (c < 3) ? STL : RUNC,
                          (c != 0) ? 4'b0000 : ((v == 0) ? 4'b0100 : 4'b0001)});
            @(negedge clk);
            e = sb.pop_front();
            n_total++;
            if (obs !== {e, e.fwd})
               $display("FAIL load_use[%0d.%0d] got %b want %b", v, c, obs, {e, e.fwd});
            else n_pass++;
            advance(e);
         end
      end
      // No hazard: operand not read, rd=%g0, load not writing
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         ex_load = 1'b1;
         case (c)
            0: begin ex_we = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd5; end
            1: begin ex_we = 1'b1; id_use_rs1 = 1'b1; end
            default: begin ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; end
         endcase
         sb.push_back({RUNC, RUNC, (c == 0) ? 4'b0101 : 4'b0000});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (obs !== {e, e.fwd})
            $display("FAIL no_hazard[%0d] got %b want %b", c, obs, {e, e.fwd});
         else n_pass++;
         advance(e);
      end
      n_total++;
      if (cnt_obs !== {m_st1, m_an1, m_st3, m_an3})
         $display("FAIL load_use_cnt got %h want %h", cnt_obs, {m_st1, m_an1, m_st3, m_an3});
      else n_pass++;
   endtask

   task automatic test_branch();
      exp_t e;
      logic [4:0] st [8];   // {jmpl, branch, taken, uncond, annul}
      logic [5:0] ex [8];
      st = '{5'b01001, 5'b01111, 5'b01100, 5'b01101,
             5'b01000, 5'b11100, 5'b10000, 5'b00101};
      ex = '{6'b111000, 6'b111010, 6'b110010, 6'b110010,
             6'b110000, 6'b110001, 6'b110001, 6'b110000};
      for (int i = 0; i < 8; i++) begin
         clear_inputs();
         {id_jmpl, id_branch, id_taken, id_uncond, id_annul} = st[i];
         sb.push_back({ex[i], ex[i], 4'b0000});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (obs !== {e, e.fwd})
            $display("FAIL branch[%0d] got %b want %b", i, obs, {e, e.fwd});
         else n_pass++;
         advance(e);
      end
      n_total++;
      if (cnt_obs !== {m_st1, m_an1, m_st3, m_an3})
         $display("FAIL annul_cnt got %h want %h", cnt_obs, {m_st1, m_an1, m_st3, m_an3});
      else n_pass++;
   endtask

   task automatic test_forwarding();
      exp_t e;
      logic [4:0] xr [8];
      logic [2:0] we [8];   // {ex_we, mem_we, wb_we}
      logic [4:0] r1 [8];
      logic [4:0] r2 [8];
      logic [3:0] fx [8];   // {fwd_a, fwd_b}
      xr = '{5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd3};
      we = '{3'b111, 3'b011, 3'b001, 3'b000, 3'b111, 3'b111, 3'b110, 3'b111};
      r1 = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd3};
      r2 = '{5'd7, 5'd7, 5'd7, 5'd7, 5'd0, 5'd7, 5'd3, 5'd7};
      fx = '{4'b0001, 4'b0010, 4'b0011, 4'b0000,
             4'b0000, 4'b0101, 4'b0100, 4'b0110};
      for (int i = 0; i < 8; i++) begin
         clear_inputs();
         ex_rd = xr[i]; mem_rd = 5'd7; wb_rd = 5'd7;
         {ex_we, mem_we, wb_we} = we[i];
         id_rs1 = r1[i]; id_rs2 = r2[i];
         id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
         sb.push_back({RUNC, RUNC, fx[i]});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (obs !== {e, e.fwd})
            $display("FAIL fwd[%0d] got %b want %b", i, obs, {e, e.fwd});
         else n_pass++;
         advance(e);
      end
   endtask

   // Stall beats JMPL/branch; then reset lands while dut3 sits in STALL
   task automatic test_back_to_back();
      exp_t e;
      clear_inputs();
      ex_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      id_branch = 1'b1; id_taken = 1'b1; id_jmpl = 1'b1;
      sb.push_back({STL, STL, 4'b0100});
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      if (obs !== {e, e.fwd}) $display("FAIL prio_stall got %b want %b", obs, {e, e.fwd});
      else n_pass++;
      advance(e);

      clear_inputs();
      id_branch = 1'b1; id_taken = 1'b1;
      sb.push_back({6'b110010, STL, 4'b0000});
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      if (obs !== {e, e.fwd}) $display("FAIL held_branch got %b want %b", obs, {e, e.fwd});
      else n_pass++;

      #1 R = 1'b0;
      m_st1 = '0; m_an1 = '0; m_st3 = '0; m_an3 = '0;
      sb.push_back({6'b110010, 6'b110010, 4'b0000});
      #1;
      e = sb.pop_front();
      n_total++;
      if (obs !== {e, e.fwd}) $display("FAIL async_reset_ctl got %b want %b", obs, {e, e.fwd});
      else n_pass++;
      n_total++;
      if (cnt_obs !== 40'd0) $display("FAIL async_reset_cnt got %h want %h", cnt_obs, 40'd0);
      else n_pass++;
      advance(e);

      @(negedge clk);
      n_total++;
      if (cnt_obs !== {m_st1, m_an1, m_st3, m_an3})
         $display("FAIL reset_hold_cnt got %h want %h", cnt_obs, {m_st1, m_an1, m_st3, m_an3});
      else n_pass++;
      R = 1'b1;
      clear_inputs();
      sb.push_back({RUNC, RUNC, 4'b0000});
      @(negedge clk);
      e = sb.pop_front();
      n_total++;
      if (obs !== {e, e.fwd}) $display("FAIL post_reset got %b want %b", obs, {e, e.fwd});
      else n_pass++;
      advance(e);
   endtask

   // Persistent hazard: both stall every cycle; dut3's 4-bit counter wraps
   task automatic test_wrap();
      exp_t e;
      for (int c = 0; c < 19; c++) begin
         clear_inputs();
         if (c < 16) begin
            ex_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
            sb.push_back({STL, STL, 4'b0001});
         end else begin
            sb.push_back({RUNC, (c < 18) ? STL : RUNC, 4'b0000});
         end
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (obs !== {e, e.fwd})
            $display("FAIL wrap[%0d] got %b want %b", c, obs, {e, e.fwd});
         else n_pass++;
         advance(e);
         if (c == 15) begin
            n_total++;
            if (cnt_obs !== {m_st1, m_an1, m_st3, m_an3})
               $display("FAIL wrap_cnt got %h want %h", cnt_obs, {m_st1, m_an1, m_st3, m_an3});
            else n_pass++;
         end
      end
      n_total++;
      if (cnt_obs !== {m_st1, m_an1, m_st3, m_an3})
         $display("FAIL final_cnt got %h want %h", cnt_obs, {m_st1, m_an1, m_st3, m_an3});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_forwarding();
      test_back_to_back();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
